// File: rtl/fetch_queue.sv
// fetch_queue
//   Decoupling buffer between the IF and ID stages. Each valid {pc, instruction}
//   fetch is captured into a DEPTH-entry circular FIFO. One entry per cycle is
//   presented to ID as the registered id_pc / id_instruction / id_no_op bundle.
//   When the queue is empty and ID is accepting, a fetch bypasses the array and
//   reaches ID one edge later. A flush discards every queued fetch.
//
// Ports
//   clk             single clock, rising edge
//   rst             synchronous active-high reset
//   if_no_op        1 = pc/instruction this cycle are not a valid fetch
//   pc, instruction fetched PC and instruction word
//   flush           discard all queued and in-flight instructions
//   hazard_control  ID-side control: NORMAL / NO_OP / RETRY (others = NORMAL)
//   id_no_op        registered; 1 = ID must not execute id_instruction
//   id_pc           registered PC presented to ID
//   id_instruction  registered instruction presented to ID
//   queue_full      count == DEPTH
//   queue_empty     count == 0
//   queue_count     registered occupancy

`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef HAZD_CTL_WIDTH
`define HAZD_CTL_WIDTH 2
`endif
`ifndef HAZD_CTL_NORMAL
`define HAZD_CTL_NORMAL 2'd0
`endif
`ifndef HAZD_CTL_NO_OP
`define HAZD_CTL_NO_OP 2'd1
`endif
`ifndef HAZD_CTL_RETRY
`define HAZD_CTL_RETRY 2'd2
`endif

module fetch_queue #(
    parameter int DEPTH     = 4,
    parameter int ISA_WIDTH = `ISA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_no_op,
    input  logic [ISA_WIDTH-1:0]       pc,
    input  logic [ISA_WIDTH-1:0]       instruction,
    input  logic                       flush,
    input  logic [`HAZD_CTL_WIDTH-1:0] hazard_control,
    output logic                       id_no_op,
    output logic [ISA_WIDTH-1:0]       id_pc,
    output logic [ISA_WIDTH-1:0]       id_instruction,
    output logic                       queue_full,
    output logic                       queue_empty,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [ISA_WIDTH-1:0] mem_pc  [DEPTH];
    logic [ISA_WIDTH-1:0] mem_ins [DEPTH];
    logic [AW-1:0]        wp, rp;
    logic [AW:0]          count;

    logic is_normal, is_retry;
    logic push_req, push_ok;
    logic do_pop, do_bypass, do_write;

    always_comb begin
        is_retry  = (hazard_control == `HAZD_CTL_RETRY);
        // anything that is neither NO_OP nor RETRY behaves as NORMAL
        is_normal = !is_retry && (hazard_control != `HAZD_CTL_NO_OP);
        push_req  = !if_no_op;
        // acceptance is judged on the registered count, not on a same-cycle pop
        push_ok   = push_req && (count < FULL_CNT);
        do_pop    = is_normal && (count != '0);
        do_bypass = is_normal && (count == '0) && push_req;
        // a bypassed fetch goes straight to ID and never touches the array
        do_write  = push_ok && !(is_normal && (count == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_write) begin
            mem_pc[wp]  <= pc;
            mem_ins[wp] <= instruction;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count          <= '0;
            wp             <= '0;
            rp             <= '0;
            id_no_op       <= 1'b1;
            id_pc          <= '0;
            id_instruction <= '0;
        end else if (flush) begin
            count    <= '0;
            wp       <= '0;
            rp       <= '0;
            id_no_op <= 1'b1;
        end else begin
            if (do_write)
                wp <= wp + 1'b1;

            if (do_pop) begin
                rp             <= rp + 1'b1;
                id_pc          <= mem_pc[rp];
                id_instruction <= mem_ins[rp];
                id_no_op       <= 1'b0;
            end else if (do_bypass) begin
                id_pc          <= pc;
                id_instruction <= instruction;
                id_no_op       <= 1'b0;
            end else if (!is_retry) begin
                id_no_op <= 1'b1;
            end

            case ({do_write, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign queue_full  = (count == FULL_CNT);
    assign queue_empty = (count == '0);
    assign queue_count = count;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the IF stage (instruction memory + PC) and the ID stage. Captures each valid `{pc, instruction}` pair fetched by IF into a small circular FIFO and presents one entry per cycle to ID as the registered `id_pc` / `id_instruction` / `id_no_op` bundle. It replaces a plain IF/ID register: ID stalls (`HAZD_CTL_RETRY`) no longer force IF to stall until the queue fills, and a taken branch or jump flushes all speculatively fetched entries.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, ≥ 2
- `ISA_WIDTH`, `` `ISA_WIDTH `` (32), width of pc and instruction
- `clk` input 1, single clock; all state updates on rising edge
- `rst` input 1, synchronous, active-high reset
- `if_no_op` input 1, from IF stage; 1 = `pc`/`instruction` this cycle are not a valid fetch
- `pc` input ISA_WIDTH, PC of the fetched instruction
- `instruction` input ISA_WIDTH, fetched instruction word; stable before the rising edge
- `flush` input 1, from signal_mux (`pc_offset | pc_overload`); discard all queued and in-flight instructions
- `hazard_control` input `` `HAZD_CTL_WIDTH ``, from hazard_unit, ID-side control: `HAZD_CTL_NORMAL` / `HAZD_CTL_NO_OP` / `HAZD_CTL_RETRY`
- `id_no_op` output 1, registered; 1 = ID must not execute `id_instruction`
- `id_pc` output ISA_WIDTH, registered PC presented to ID
- `id_instruction` output ISA_WIDTH, registered instruction presented to ID
- `queue_full` output 1, combinational `count == DEPTH`; hazard_unit uses it to issue `HAZD_CTL_RETRY` to IF
- `queue_empty` output 1, combinational `count == 0`
- `queue_count` output log2(DEPTH)+1, registered occupancy

## Operation
- Storage: DEPTH-entry array of `{pc, instruction}`, write pointer `wp`, read pointer `rp`, counter `count`. Pointers are log2(DEPTH) bits and wrap DEPTH-1 → 0 naturally.
- push_req = `~if_no_op`. A push is accepted iff push_req && `count < DEPTH` (judged on the registered count, independent of a same-cycle pop). If the queue is full, the fetch is dropped; hazard_unit must hold IF via RETRY.
- Priority per edge: `rst` > `flush` > `hazard_control` action.
- `rst`: count=0, wp=rp=0, id_no_op=1, id_pc=0, id_instruction=0. Array contents are don't-care.
- `flush`: count=0, wp=rp=0, id_no_op=1; the same-cycle push is discarded. id_pc/id_instruction hold. `hazard_control` is ignored.
- `HAZD_CTL_NORMAL`:
  - count>0: load head entry into outputs, id_no_op=0, rp+1, count−1. An accepted push in the same cycle writes at wp, wp+1, count+1, for a net count change of 0.
  - count==0 and push_req (bypass): load input `pc`/`instruction` directly into outputs, id_no_op=0. The array is not written and count stays 0.
  - count==0, no push_req: id_no_op=1, id_pc/id_instruction hold.
- `HAZD_CTL_NO_OP`: id_no_op=1, no pop, outputs hold. An accepted push is enqueued.
- `HAZD_CTL_RETRY`: id_no_op, id_pc and id_instruction all hold. No pop. An accepted push is enqueued.
- Any other encoding is treated as `HAZD_CTL_NORMAL`.
- Instruction order is strictly FIFO. No entry is duplicated or lost except on flush or a push rejected while full.

## Timing
- Latency IF→ID: 1 cycle on bypass (empty queue, NORMAL). Otherwise an entry appears at the output on the first NORMAL edge where it is at the head.
- Throughput: one push and one pop per cycle sustained.
- `queue_full` and `queue_empty` follow the registered count and change only after a clock edge.
- A flush asserted in cycle N gives id_no_op=1 from edge N. The first post-flush fetch, presented in cycle N+1 with NORMAL, reaches ID at edge N+1 via bypass.
- `rst` asserted mid-operation takes effect on the next edge and overrides a simultaneous flush, push and pop.

## Test plan
- Reset, then NORMAL with fetches at pc 0,4,8 on consecutive cycles → id_pc 0,4,8 one edge after each fetch; id_no_op=0; queue_count stays 0 throughout.
- RETRY for 3 cycles while pushing pc 0x10,0x14,0x18, then NORMAL with no fetches → outputs hold during RETRY; count reaches 3; then id_pc 0x10,0x14,0x18 on the next 3 edges; count 2,1,0.
- RETRY with 5 fetches, DEPTH=4 → queue_full=1 after 4 pushes and the 5th is dropped; on resume ID sees exactly the first 4 PCs in order.
- Count=3 and flush asserted together with a push and NORMAL → count=0, id_no_op=1, pushed entry absent; next fetch pc 0x40 appears at ID one edge later.
- Fill and drain the queue 3 times with NORMAL+push at count=2 → pointers wrap past DEPTH-1 and the output PC sequence stays continuous with no gaps or repeats.
- `rst` asserted while count=2 and RETRY → next edge gives count=0, id_no_op=1, id_pc=0, id_instruction=0, queue_empty=1.
